// File: rtl/stdout_uart.sv
// stdout_uart: prints each 16-bit word from the TOY core's stdout port.
// Each word goes out on an 8N1 UART line as four uppercase ASCII hex digits
// followed by a line terminator. Words wait in a small FIFO until they are sent.
// Optional feature macro: STDOUT_UART_CRLF_EN. When defined, the terminator is
// CR LF (six frames per word). When undefined, it is LF only (five frames).
module stdout_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        val_i,
  input  logic [15:0] data_i,
  output logic        rdy_o,
  output logic        txd_o,
  output logic        busy_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

`ifdef STDOUT_UART_CRLF_EN
  localparam logic [2:0] CHAR_LAST = 3'd5;  // 4 digits, CR, LF
  localparam logic [7:0] TERM0     = 8'h0D;
`else
  localparam logic [2:0] CHAR_LAST = 3'd4;  // 4 digits, LF
  localparam logic [7:0] TERM0     = 8'h0A;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             nonempty_q;
  logic             full;
  logic             push;
  logic             pop;

  assign full  = (count == FULL_CNT);
  // Held low during reset. A full FIFO never accepts a word, even in a pop cycle.
  assign rdy_o = !rst_i && !full;
  assign push  = val_i && rdy_o;

  // Storage array: only written when a word is accepted.
  // NOTE: the data array is not reset. Count and pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FIFO pointers, occupancy and the delayed non-empty flag seen by the formatter.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      nonempty_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // One cycle behind the count: a word accepted at edge N is popped at N+2.
      nonempty_q <= (count != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Formatter and 8N1 transmitter
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [2:0]        char_idx;
  logic [15:0]       hold;
  logic [3:0]        nib;
  logic [7:0]        cur_char;
  logic              baud_done;
  logic              word_done;

  assign baud_done = (baud == BAUD_LAST);
  assign word_done = (char_idx == CHAR_LAST);

  // A pop happens when leaving IDLE, or at the end of the last stop bit of a word.
  assign pop = nonempty_q && (count != '0) &&
               ((state == IDLE) || ((state == STOP) && baud_done && word_done));

  assign busy_o = (state != IDLE) || (count != '0);

  // Pick the character at char_idx: hex digits MSB nibble first, then the terminator.
  // NOTE: every output gets a default first, so this combinational block cannot infer a latch.
  always_comb begin
    nib      = 4'h0;
    cur_char = 8'h0A;
    case (char_idx)
      3'd0:    nib = hold[15:12];
      3'd1:    nib = hold[11:8];
      3'd2:    nib = hold[7:4];
      3'd3:    nib = hold[3:0];
      default: nib = 4'h0;
    endcase
    if (char_idx < 3'd4) begin
      cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (char_idx == 3'd4) begin
      cur_char = TERM0;
    end
  end

  // Frame sequencer: one bit time per state step; txd_o is registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      hold     <= '0;
      txd_o    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          txd_o <= 1'b1;
          baud  <= '0;
          if (pop) begin
            hold     <= mem[rd_ptr];
            char_idx <= '0;
            txd_o    <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            txd_o   <= cur_char[0];
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              txd_o <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_o   <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (!word_done) begin
              char_idx <= char_idx + 3'd1;
              txd_o    <= 1'b0;
              state    <= START;
            end else if (pop) begin
              // Back-to-back words: start the next one with no idle gap.
              hold     <= mem[rd_ptr];
              char_idx <= '0;
              txd_o    <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          txd_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_uart.sv
// Testbench for stdout_uart. Two instances share the clock and reset:
// dut_a runs at 4 clocks per bit and dut_b at 1 clock per bit.
// Follows STDOUT_UART_CRLF_EN the same way as the design.
module tb_stdout_uart;

  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

`ifdef STDOUT_UART_CRLF_EN
  localparam int         NFR   = 6;
  localparam logic [7:0] TERM0 = 8'h0D;
`else
  localparam int         NFR   = 5;
  localparam logic [7:0] TERM0 = 8'h0A;
`endif

  typedef logic [5:0][7:0] bytes_t;

  typedef struct {
    logic [15:0] word;
    logic [31:0] digits;  // expected ASCII digits, first character in the top byte
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        val_a = 1'b0;
  logic [15:0] data_a = '0;
  logic        rdy_a, txd_a, busy_a;
  logic        val_b = 1'b0;
  logic [15:0] data_b = '0;
  logic        rdy_b, txd_b, busy_b;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  stdout_uart #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .val_i (val_a),
    .data_i(data_a),
    .rdy_o (rdy_a),
    .txd_o (txd_a),
    .busy_o(busy_a)
  );

  stdout_uart #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .val_i (val_b),
    .data_i(data_b),
    .rdy_o (rdy_b),
    .txd_o (txd_b),
    .busy_o(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bytes_t mk_exp(input logic [31:0] digits);
    bytes_t e;
    e[0] = digits[31:24];
    e[1] = digits[23:16];
    e[2] = digits[15:8];
    e[3] = digits[7:0];
    e[4] = TERM0;
    e[5] = 8'h0A;
    return e;
  endfunction

  // Offer one word at a negedge, wait (bounded) for rdy, and return at the
  // negedge that follows the accepting edge.
  task automatic push(input bit sel, input logic [15:0] w);
    int n;
    n = 0;
    if (sel) begin val_b = 1'b1; data_b = w; end
    else     begin val_a = 1'b1; data_a = w; end
    while (((sel ? rdy_b : rdy_a) !== 1'b1) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check("push_rdy_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (sel) val_b = 1'b0;
    else     val_a = 1'b0;
  endtask

  // Count negedges until the line goes low (bounded).
  task automatic wait_start(input bit sel, input int limit, output int waited);
    waited = 0;
    while (((sel ? txd_b : txd_a) !== 1'b0) && (waited < limit)) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Decode one frame. Entry: at the first sample of the start bit. Exit: at
  // the last sample of the stop bit. Every bit must be stable for cpb samples.
  task automatic rx_frame(input bit sel, input int cpb, output logic [7:0] b, output bit good);
    logic v;
    logic first;
    good  = 1'b1;
    b     = '0;
    first = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < cpb; j++) begin
        if ((k != 0) || (j != 0)) @(negedge clk);
        v = sel ? txd_b : txd_a;
        if ((sel ? busy_b : busy_a) === 1'b1) busy_cnt++;
        if (j == 0) begin
          first = v;
          if ((k == 0) && (v !== 1'b0)) good = 1'b0;
          if ((k == 9) && (v !== 1'b1)) good = 1'b0;
          if ((k >= 1) && (k <= 8)) b[k-1] = v;
        end else if (v !== first) begin
          good = 1'b0;
        end
      end
    end
  endtask

  // Decode one word's frames back to back. Each frame must start on the
  // sample right after the previous stop bit.
  task automatic rx_word(input bit sel, input int cpb, input bytes_t exp,
                         input string tag, input bit chk_busy);
    logic [7:0] b;
    bit         good;
    busy_cnt = 0;
    for (int f = 0; f < NFR; f++) begin
      if (f > 0) @(negedge clk);
      rx_frame(sel, cpb, b, good);
      check({tag, "_frame_shape"}, 32'(good), 32'd1);
      check({tag, "_byte"}, 32'(b), 32'(exp[f]));
    end
    if (chk_busy) check({tag, "_busy_len"}, 32'(busy_cnt), 32'(NFR * 10 * cpb));
  endtask

  vec_t vecs [5];
  int   w;
  int   bad;

  initial begin
    // Hand-computed ASCII for each word.
    vecs[0] = '{word: 16'h1A2F, digits: 32'h31413246};
    vecs[1] = '{word: 16'hFFFF, digits: 32'h46464646};
    vecs[2] = '{word: 16'h0000, digits: 32'h30303030};
    vecs[3] = '{word: 16'h9B05, digits: 32'h39423035};
    vecs[4] = '{word: 16'hC3E7, digits: 32'h43334537};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_txd_a", 32'(txd_a), 32'd1);
    check("rst_rdy_a", 32'(rdy_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_txd_b", 32'(txd_b), 32'd1);
    check("rst_rdy_b", 32'(rdy_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy_a", 32'(rdy_a), 32'd1);
    check("post_rst_rdy_b", 32'(rdy_b), 32'd1);
    check("post_rst_busy_a", 32'(busy_a), 32'd0);

    // Single words, table-driven: start bit two edges after accept, exact bytes, busy length.
    for (int i = 0; i < 5; i++) begin
      push(1'b0, vecs[i].word);
      wait_start(1'b0, 100, w);
      check("vec_latency", 32'(w), 32'd2);
      rx_word(1'b0, CPB_A, mk_exp(vecs[i].digits), "vec", 1'b1);
      @(negedge clk);
      check("vec_busy_drop", 32'(busy_a), 32'd0);
      check("vec_txd_idle", 32'(txd_a), 32'd1);
    end

    // Backpressure: words 0..5 with val held high. rdy drops after five accepts,
    // and all 30 frames are contiguous.
    fork
      begin : pusher
        int n;
        val_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
          data_a = 16'(i);
          n = 0;
          while ((rdy_a !== 1'b1) && (n < 2000)) begin
            @(negedge clk);
            n++;
          end
          if (i < 5) check("bp_rdy_high", 32'(n), 32'd0);
          else       check("bp_last_accept_timeout", 32'(n < 2000), 32'd1);
          @(posedge clk);
          @(negedge clk);
          if (i == 4) check("bp_rdy_low_after_5", 32'(rdy_a), 32'd0);
        end
        val_a = 1'b0;
      end
      begin : receiver
        int ws;
        wait_start(1'b0, 100, ws);
        check("bp_start_timeout", 32'(ws < 100), 32'd1);
        for (int wd = 0; wd < 6; wd++) begin
          if (wd > 0) @(negedge clk);
          rx_word(1'b0, CPB_A, mk_exp({8'h30, 8'h30, 8'h30, 8'h30 + 8'(wd)}), "bp", 1'b0);
        end
      end
    join
    @(negedge clk);
    check("bp_busy_drop", 32'(busy_a), 32'd0);

    // Reset during DATA of the second character, with a second word queued.
    push(1'b0, 16'h1234);
    push(1'b0, 16'h5678);
    wait_start(1'b0, 100, w);
    check("mid_rst_start_timeout", 32'(w < 100), 32'd1);
    begin
      logic [7:0] b;
      bit         good;
      rx_frame(1'b0, CPB_A, b, good);
      check("mid_rst_char0", 32'(b), 32'h31);
    end
    @(negedge clk);                      // start bit of '2' (0x32)
    repeat (CPB_A) @(negedge clk);       // data bit 0 of 0x32, which is 0
    check("mid_rst_pre_low", 32'(txd_a), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txd_async", 32'(txd_a), 32'd1);
    check("mid_rst_rdy", 32'(rdy_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_txd_held", 32'(txd_a), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy_after", 32'(rdy_a), 32'd1);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ((txd_a !== 1'b1) || (busy_a !== 1'b0)) bad++;
      @(negedge clk);
    end
    check("mid_rst_silent_after", 32'(bad), 32'd0);

    // Minimum bit time on dut_b.
    push(1'b1, 16'h0009);
    wait_start(1'b1, 100, w);
    check("min_latency", 32'(w), 32'd2);
    rx_word(1'b1, CPB_B, mk_exp(32'h30303039), "min", 1'b1);
    @(negedge clk);
    check("min_busy_drop", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
